// File: rtl/mips_encode_loader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_encode_loader_pkg: opcode/funct codes, formats, states, packer      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mips_encode_loader_pkg;

   // Primary opcode field values shared with mips_decode
   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_ADDI    = 6'h08;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0A;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2B;

   // Funct field values for OP_SPECIAL
   localparam logic [5:0] OP0_SLL  = 6'h00;
   localparam logic [5:0] OP0_SRL  = 6'h02;
   localparam logic [5:0] OP0_JR   = 6'h08;
   localparam logic [5:0] OP0_ADD  = 6'h20;
   localparam logic [5:0] OP0_ADDU = 6'h21;
   localparam logic [5:0] OP0_SUB  = 6'h22;
   localparam logic [5:0] OP0_AND  = 6'h24;
   localparam logic [5:0] OP0_OR   = 6'h25;
   localparam logic [5:0] OP0_XOR  = 6'h26;
   localparam logic [5:0] OP0_NOR  = 6'h27;
   localparam logic [5:0] OP0_SLT  = 6'h2A;

   localparam logic [1:0] FMT_R   = 2'd0;
   localparam logic [1:0] FMT_I   = 2'd1;
   localparam logic [1:0] FMT_J   = 2'd2;
   localparam logic [1:0] FMT_BAD = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic logic [31:0] encode_word(
      input logic [1:0]  fmt,
      input logic [5:0]  opcode,
      input logic [4:0]  rs,
      input logic [4:0]  rt,
      input logic [4:0]  rd,
      input logic [4:0]  shamt,
      input logic [5:0]  funct,
      input logic [15:0] imm,
      input logic [25:0] target
   );
      logic [31:0] word;
      word = 32'd0;
      case (fmt)
         FMT_R:   word = {opcode, rs, rt, rd, shamt, funct};
         FMT_I:   word = {opcode, rs, rt, imm};
         FMT_J:   word = {opcode, target};
         default: word = 32'd0;
      endcase
      return word;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mips_encode_loader_instr_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_fifo: DEPTH x WIDTH synchronous FIFO, pointer-based full/empty     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module instr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage carries no reset; validity is tracked by the pointers alone
   always_ff @(posedge clock) begin
      if (push && !full)
         mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/mips_encode_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_encode_loader: packs MIPS fields into words, writes them to memory  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mips_encode_loader
   import mips_encode_loader_pkg::*;
#(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] BASE_ADDR = 32'h00400000,
   parameter int          CNT_W     = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             finish,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_fmt,
   input  logic [5:0]       in_opcode,
   input  logic [4:0]       in_rs,
   input  logic [4:0]       in_rt,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_shamt,
   input  logic [5:0]       in_funct,
   input  logic [15:0]      in_imm,
   input  logic [25:0]      in_target,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_data,
   output logic             mem_we,
   input  logic             mem_ack,
   output logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             err
);
   state_t      state;
   state_t      state_nx;
   logic        fifo_full;
   logic        fifo_empty;
   logic [31:0] fifo_head;
   logic [31:0] enc_word;
   logic        accept;
   logic        push;
   logic        ack;
   logic        load_out;
   logic        enter_run;
   logic        out_valid;

   always_ff @(posedge clock) begin
      if (!reset)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (start) state_nx = ST_RUN;
         ST_RUN:   if (finish) state_nx = ST_DRAIN;
         ST_DRAIN: if (fifo_empty && !out_valid) state_nx = ST_DONE;
         ST_DONE:  if (start) state_nx = ST_RUN;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state == ST_RUN) || (state == ST_DRAIN);
      done     = (state == ST_DONE);
      in_ready = (state == ST_RUN) && !fifo_full;
   end

   assign enter_run = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign accept    = in_valid && in_ready;
   assign push      = accept && (in_fmt != FMT_BAD);
   assign enc_word  = encode_word(in_fmt, in_opcode, in_rs, in_rt, in_rd,
                                  in_shamt, in_funct, in_imm, in_target);
   assign ack       = out_valid && mem_ack;
   // Refill on the ack edge itself so a held ack streams one word per cycle
   assign load_out  = !fifo_empty && (!out_valid || mem_ack);
   assign mem_we    = out_valid;

   instr_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (enc_word),
      .pop       (load_out),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         out_valid <= 1'b0;
         mem_data  <= 32'd0;
         mem_addr  <= BASE_ADDR;
         count     <= '0;
         err       <= 1'b0;
      end else begin
         if (load_out) begin
            mem_data  <= fifo_head;
            out_valid <= 1'b1;
         end else if (ack) begin
            out_valid <= 1'b0;
         end

         if (enter_run) begin
            mem_addr <= BASE_ADDR;
            count    <= '0;
            err      <= 1'b0;
         end else begin
            if (ack) begin
               mem_addr <= mem_addr + 32'd4;
               if (count != {CNT_W{1'b1}})
                  count <= count + 1'b1;
            end
            if (accept && (in_fmt == FMT_BAD))
               err <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mips_encode_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mips_encode_loader: directed stimulus with an expected-write queue    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mips_encode_loader;
   localparam logic [31:0] BASE = 32'h00400000;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        finish = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_fmt = 2'd0;
   logic [5:0]  in_opcode = 6'd0;
   logic [4:0]  in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0, in_shamt = 5'd0;
   logic [5:0]  in_funct = 6'd0;
   logic [15:0] in_imm = 16'd0;
   logic [25:0] in_target = 26'd0;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic        mem_we;
   logic        mem_ack = 1'b0;
   logic [15:0] count;
   logic        busy, done, err;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   wr_t         q[$];
   int          wr_cyc[$];
   logic [31:0] exp_addr = BASE;

   mips_encode_loader #(.DEPTH(4), .BASE_ADDR(BASE), .CNT_W(16)) dut (
      .clock(clock), .reset(reset), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
      .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm),
      .in_target(in_target), .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_we(mem_we), .mem_ack(mem_ack), .count(count), .busy(busy),
      .done(done), .err(err)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Write monitor: each acknowledged write must match the oldest expected entry
   always @(negedge clock) begin
      if (reset && mem_we && mem_ack) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_write observed=%h@%h expected=none", mem_data, mem_addr);
         end else begin
            wr_t e;
            e = q.pop_front();
            chk("wr_addr", mem_addr, e.addr);
            chk("wr_data", mem_data, e.data);
         end
         wr_cyc.push_back(cyc);
      end
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [1:0] fmt, input logic [5:0] op,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh,
                       input logic [5:0] fn, input logic [15:0] imm,
                       input logic [25:0] tgt, input logic [31:0] exp_word);
      int n;
      in_valid = 1'b1; in_fmt = fmt; in_opcode = op; in_rs = rs; in_rt = rt;
      in_rd = rd; in_shamt = sh; in_funct = fn; in_imm = imm; in_target = tgt;
      n = 0;
      @(negedge clock);
      while (!in_ready && n < 40) begin
         @(negedge clock);
         n++;
      end
      chk("accept_timeout", 32'(n < 40), 32'd1);
      if (n < 40 && fmt != 2'd3) begin
         wr_t e;
         e.addr = exp_addr;
         e.data = exp_word;
         q.push_back(e);
         exp_addr = exp_addr + 32'd4;
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic start_session;
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_addr = BASE;
   endtask

   task automatic wait_drain;
      int n;
      n = 0;
      @(negedge clock);
      while ((q.size() != 0 || mem_we) && n < 60) begin
         @(negedge clock);
         n++;
      end
      chk("drain_timeout", 32'(n < 60), 32'd1);
   endtask

   initial begin
      logic [31:0] hold_addr, hold_data;
      int n;

      // Reset state
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_addr", mem_addr, BASE);
      chk("rst_data", mem_data, 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_flags", {28'd0, err, done, busy, in_ready}, 32'd0);
      tick();
      reset = 1'b1;
      tick();

      start_session();
      @(negedge clock);
      chk("run_flags", {30'd0, busy, in_ready}, 32'd3);
      tick();

      // xori with junk in unused fields
      mem_ack = 1'b1;
      send(2'd1, 6'h0E, 5'd9, 5'd8, 5'h1F, 5'h1F, 6'h3F, 16'h00FF, 26'h3FFFFFF, 32'h392800FF);
      wait_drain();
      chk("xori_count", 32'(count), 32'd1);
      tick();

      // slt then j, back to back
      exp_addr = BASE + 32'd4;
      send(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h2A, 16'hFFFF, 26'd0, 32'h0022182A);
      send(2'd2, 6'h02, 5'd7, 5'd7, 5'd7, 5'd7, 6'h3F, 16'hFFFF, 26'h0100004, 32'h08100004);
      wait_drain();
      chk("b2b_gap", 32'(wr_cyc[$] - wr_cyc[$-1]), 32'd1);
      chk("slt_j_count", 32'(count), 32'd3);
      tick();

      // Backpressure: five words fit, the sixth is refused
      mem_ack = 1'b0;
      for (int k = 1; k <= 5; k++)
         send(2'd1, 6'h09, 5'd0, 5'(k), 5'd0, 5'd0, 6'd0, 16'(k),
              26'd0, {6'h09, 5'd0, 5'(k), 16'(k)});
      @(negedge clock);
      hold_addr = mem_addr;
      hold_data = mem_data;
      chk("bp_hold_addr0", mem_addr, BASE + 32'd12);
      in_valid = 1'b1; in_fmt = 2'd1; in_opcode = 6'h09; in_rt = 5'd6; in_imm = 16'd6;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         chk("bp_ready", 32'(in_ready), 32'd0);
      end
      chk("bp_we", 32'(mem_we), 32'd1);
      chk("bp_addr_stable", mem_addr, hold_addr);
      chk("bp_data_stable", mem_data, hold_data);
      tick();
      in_valid = 1'b0;
      mem_ack = 1'b1;
      wait_drain();
      chk("bp_count", 32'(count), 32'd8);
      tick();

      // Illegal format in mid-stream
      send(2'd0, 6'h00, 5'd4, 5'd5, 5'd6, 5'd0, 6'h20, 16'd0, 26'd0, 32'h00853020);
      send(2'd3, 6'h3F, 5'd1, 5'd1, 5'd1, 5'd1, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 32'd0);
      send(2'd1, 6'h0D, 5'd0, 5'd7, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0, 32'h34071234);
      wait_drain();
      chk("bad_count", 32'(count), 32'd10);
      chk("bad_err", 32'(err), 32'd1);
      tick();

      // finish with three words buffered
      mem_ack = 1'b0;
      for (int k = 0; k < 3; k++)
         send(2'd1, 6'h0F, 5'd0, 5'(k + 10), 5'd0, 5'd0, 6'd0, 16'hA000 + 16'(k),
              26'd0, {6'h0F, 5'd0, 5'(k + 10), 16'hA000 + 16'(k)});
      finish = 1'b1;
      tick();
      finish = 1'b0;
      @(negedge clock);
      chk("fin_ready", 32'(in_ready), 32'd0);
      chk("fin_busy_done", {30'd0, busy, done}, 32'd2);
      tick();
      mem_ack = 1'b1;
      n = 0;
      @(negedge clock);
      while (!done && n < 40) begin
         chk("fin_busy_hold", 32'(busy), 32'd1);
         @(negedge clock);
         n++;
      end
      chk("fin_done", 32'(done), 32'd1);
      chk("fin_busy_low", 32'(busy), 32'd0);
      chk("fin_count", 32'(count), 32'd13);
      chk("fin_err_sticky", 32'(err), 32'd1);
      chk("fin_queue", 32'(q.size()), 32'd0);
      tick();

      // Restart from DONE, then reset during an outstanding write
      start_session();
      @(negedge clock);
      chk("restart_count", 32'(count), 32'd0);
      chk("restart_err", 32'(err), 32'd0);
      tick();
      send(2'd2, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000040, 32'h0C000040);
      wait_drain();
      chk("restart_cnt1", 32'(count), 32'd1);
      tick();
      mem_ack = 1'b0;
      send(2'd3, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 32'd0);
      send(2'd1, 6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0001, 26'd0, 32'h20220001);
      send(2'd1, 6'h08, 5'd1, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0002, 26'd0, 32'h20230002);
      @(negedge clock);
      chk("prerst_we", 32'(mem_we), 32'd1);
      chk("prerst_err", 32'(err), 32'd1);
      tick();
      q.delete();
      reset = 1'b0;
      tick();
      @(negedge clock);
      chk("mid_rst_we", 32'(mem_we), 32'd0);
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_addr", mem_addr, BASE);
      chk("mid_rst_flags", {28'd0, err, done, busy, in_ready}, 32'd0);
      tick();
      reset = 1'b1;
      mem_ack = 1'b1;
      tick();
      start_session();
      send(2'd0, 6'h00, 5'd0, 5'd0, 5'd0, 5'd4, 6'h00, 16'd0, 26'd0, 32'h00000100);
      wait_drain();
      chk("post_rst_count", 32'(count), 32'd1);
      repeat (3) @(negedge clock);
      chk("final_queue", 32'(q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/mips_encode_loader.md
Name: mips_encode_loader

Overview:
Instruction encoder and loader: the producing end of the opcode/funct interface that mips_decode consumes.
- Accepts instruction fields (format, opcode, rs, rt, rd, shamt, funct, imm, target) over a valid/ready handshake.
- Packs them into 32-bit MIPS words, buffers them in a small FIFO, and writes them sequentially into instruction memory through an ack-based write port.
- Used by the lab test harness and boot path to place programs in memory before the datapath runs.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >= 2)
BASE_ADDR, 32'h00400000, byte address of the first instruction written
CNT_W, 16, width of the words-written counter

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-low (0 = reset)
start  input  1  begin a load session (sampled in IDLE/DONE only)
finish  input  1  end of program; drain and stop (sampled in RUN only)
in_valid  input  1  instruction fields valid
in_ready  output  1  loader accepts fields this cycle
in_fmt  input  2  0=R, 1=I, 2=J, 3=illegal
in_opcode  input  6  opcode field (`OP_* values)
in_rs, in_rt, in_rd, in_shamt  input  5 each  register/shift fields
in_funct  input  6  funct field (`OP0_* values)
in_imm  input  16  immediate
in_target  input  26  jump target
mem_addr  output  32  byte address of the word being written
mem_data  output  32  encoded instruction
mem_we  output  1  write request, held until mem_ack
mem_ack  input  1  memory accepted the write this cycle
count  output  CNT_W  words written this session, saturating
busy  output  1  state is RUN or DRAIN
done  output  1  state is DONE
err  output  1  sticky: illegal format seen this session

Behaviour:
- Reset (reset==0 at an edge):
  - State IDLE; FIFO emptied; output register invalid.
  - mem_we=0, mem_addr=BASE_ADDR, mem_data=0, count=0, err=0, done=0, busy=0, in_ready=0.
  - Any outstanding write is abandoned. Reset mid-session behaves identically.
- States:
  - IDLE -(start)-> RUN
  - RUN -(finish)-> DRAIN
  - DRAIN -(FIFO empty && !mem_we)-> DONE
  - DONE -(start)-> RUN
  - Entering RUN clears count and err and sets the next address to BASE_ADDR.
  - start is ignored in RUN/DRAIN; finish is ignored outside RUN.
- in_ready = (state==RUN) && !fifo_full. It is computed from the current full flag only; no push-through-pop bypass when full.
- Accept = in_valid && in_ready. Encoding is combinational at accept and the packed word is pushed at that edge:
  - R: {opcode, rs, rt, rd, shamt, funct}
  - I: {opcode, rs, rt, imm}
  - J: {opcode, target}
  - Unused fields are ignored.
  - fmt 3: handshake completes, nothing is pushed, err set.
- finish and accept in the same cycle: the word is accepted, then the state moves to DRAIN.
- Write port:
  - The output register loads the FIFO head when it is empty, or when mem_ack is seen on the same edge.
  - mem_we is high whenever the output register is valid, with mem_addr/mem_data stable until ack.
  - On ack: mem_addr += 4 (wraps modulo 2^32), count += 1 (saturates at all-ones).
  - Back-to-back writes are allowed, so a constant mem_ack gives 1 word/cycle.
- Latency: a word accepted at edge N appears on mem_we/mem_data after edge N+1 if the output register is free.
- Capacity with mem_ack held low: DEPTH+1 words (FIFO plus output register).
- mem_ack while mem_we==0 is ignored.
- done stays high until start; busy=0 in IDLE/DONE.

Decomposition:
- Shared header/package holds the `OP_*` and `OP0_*` opcode/funct defines already used by mips_decode, plus format constants FMT_R/FMT_I/FMT_J/FMT_BAD.
- One sub-module: instr_fifo (parameterised DEPTH x 32, synchronous active-low reset, push/pop/full/empty).
- The encoder packing stays inline.

Test Plan:
- xori: start, then I-format opcode `OP_XORI (0x0E), rs=9, rt=8, imm=0x00FF, mem_ack=1 -> mem_we pulse with mem_addr=0x00400000, mem_data=0x392800FF; count=1.
- slt then j:
  - R-format opcode 0, rs=1, rt=2, rd=3, funct `OP0_SLT (0x2A) -> 0x0022182A at 0x00400000.
  - J-format `OP_J (0x02), target=0x0100004 -> 0x08100004 at 0x00400004, written on consecutive cycles.
- Backpressure: mem_ack=0, in_valid held with 6 words -> exactly 5 accepted, then in_ready=0. mem_addr/mem_data stay stable. Releasing ack drains all 5 in order at sequential addresses.
- Illegal format: in_fmt=3 mid-stream -> err=1 (sticky), count unchanged, no extra mem_we, following words still encode normally.
- finish drain: assert finish with 3 words buffered -> in_ready=0 immediately, busy=1 until the last ack, then done=1, count=3.
- Reset mid-write: reset=0 while mem_we=1 -> after that edge mem_we=0, state IDLE, count=0, err=0, FIFO empty. A new start restarts at 0x00400000.
